cosim_msg_splitter: RTL and testbench

Splits each wide message produced by the cosim from-host endpoint into a sequence of narrow beats for downstream logic. It sits directly downstream of the from-host endpoint: it consumes that endpoint's `DataOutValid`/`DataOutReady`/`DataOut` handshake and presents a valid/ready beat stream with a last-beat flag. A two-entry message buffer lets the endpoint hand over the next message while the current one is still being emitted, so beats flow back-to-back without bubbles.

---
 rtl/cosim_split_pkg.sv | 18 +
 rtl/cosim_msg_fifo2.sv | 53 +++++
 rtl/cosim_msg_splitter.sv | 117 +++++++++++
 tb/tb_cosim_msg_splitter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/cosim_split_pkg.sv
// Shared types and sizing helpers for the cosim message splitter.
package cosim_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } split_state_e;

  function automatic int num_beats(input int msg_bits, input int beat_bits);
    return (msg_bits + beat_bits - 1) / beat_bits;
  endfunction

  // A single-beat message still gets a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cosim_msg_fifo2.sv
// Two-entry message FIFO; head is always visible on rdata_o, full/empty are registered.
module cosim_msg_fifo2 #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;
  assign cnt_d   = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == 2'd2);
      empty_q <= (cnt_d == 2'd0);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/cosim_msg_splitter.sv
// Splits wide from-host messages into narrow beats, LS beat first, zero-padding the final beat.
module cosim_msg_splitter
  import cosim_split_pkg::*;
#(
  parameter  int MSG_BITS  = 96,
  parameter  int BEAT_BITS = 32,
  localparam int NUM_BEATS = num_beats(MSG_BITS, BEAT_BITS),
  localparam int IDX_W     = idx_width(NUM_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MsgValid,
  output logic                 MsgReady,
  input  logic [MSG_BITS-1:0]  Msg,
  output logic                 BeatValid,
  input  logic                 BeatReady,
  output logic [BEAT_BITS-1:0] Beat,
  output logic                 BeatLast,
  output logic [IDX_W-1:0]     BeatIdx
);

  localparam int PAD_BITS = NUM_BEATS * BEAT_BITS;

  split_state_e         state_q, state_d;
  logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [MSG_BITS-1:0]  head_msg;
  logic                 push;
  logic                 pop;
  logic                 beat_fire;
  logic                 at_last;
  logic [PAD_BITS-1:0]  padded;
  logic [BEAT_BITS-1:0] beat_arr [NUM_BEATS];
  logic [NUM_BEATS-1:0] beat_sel;
  logic [BEAT_BITS-1:0] beat_mux;

  assign MsgReady  = !fifo_full;
  assign push      = MsgValid && !fifo_full;
  assign at_last   = (beat_idx_q == IDX_W'(NUM_BEATS - 1));
  assign beat_fire = (state_q == SEND) && BeatReady;
  assign pop       = beat_fire && at_last;

  cosim_msg_fifo2 #(
    .WIDTH(MSG_BITS)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst),
    .push_i (push),
    .wdata_i(Msg),
    .pop_i  (pop),
    .rdata_o(head_msg),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
    end
  end

  // Stay in SEND across a last-beat pop if another message is queued or arriving now.
  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    case (state_q)
      IDLE: begin
        if (push) state_d = SEND;
      end
      SEND: begin
        if (beat_fire) begin
          if (at_last) begin
            beat_idx_d = '0;
            if (!(fifo_full || push)) state_d = IDLE;
          end else begin
            beat_idx_d = beat_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    padded                 = '0;
    padded[MSG_BITS-1:0]   = head_msg;
  end

  for (genvar gi = 0; gi < NUM_BEATS; gi++) begin : g_beat
    assign beat_arr[gi] = padded[gi*BEAT_BITS +: BEAT_BITS];
    assign beat_sel[gi] = (beat_idx_q == IDX_W'(gi));
  end

  always_comb begin
    beat_mux = '0;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (beat_sel[k]) beat_mux = beat_mux | beat_arr[k];
    end
  end

  // Outside SEND the head slot may hold a retired message, so the beat is forced to zero.
  always_comb begin
    BeatValid = (state_q == SEND);
    BeatLast  = (state_q == SEND) && at_last;
    Beat      = (state_q == SEND) ? beat_mux : '0;
    BeatIdx   = beat_idx_q;
  end

  logic unused_ok;
  assign unused_ok = fifo_empty;

endmodule

// File: tb/tb_cosim_msg_splitter.sv
// Directed, table-driven bench for cosim_msg_splitter in 96/32, 40/32 and 32/32 configurations.
module tb_cosim_msg_splitter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 96/32
  logic        a_mv, a_mr, a_bv, a_br, a_last;
  logic [95:0] a_msg;
  logic [31:0] a_beat;
  logic [1:0]  a_idx;
  // DUT B: 40/32
  logic        b_mv, b_mr, b_bv, b_br, b_last;
  logic [39:0] b_msg;
  logic [31:0] b_beat;
  logic [0:0]  b_idx;
  // DUT C: 32/32
  logic        c_mv, c_mr, c_bv, c_br, c_last;
  logic [31:0] c_msg;
  logic [31:0] c_beat;
  logic [0:0]  c_idx;

  cosim_msg_splitter #(.MSG_BITS(96), .BEAT_BITS(32)) dut_a (
    .clk(clk), .rst(rst), .MsgValid(a_mv), .MsgReady(a_mr), .Msg(a_msg),
    .BeatValid(a_bv), .BeatReady(a_br), .Beat(a_beat), .BeatLast(a_last), .BeatIdx(a_idx)
  );
  cosim_msg_splitter #(.MSG_BITS(40), .BEAT_BITS(32)) dut_b (
    .clk(clk), .rst(rst), .MsgValid(b_mv), .MsgReady(b_mr), .Msg(b_msg),
    .BeatValid(b_bv), .BeatReady(b_br), .Beat(b_beat), .BeatLast(b_last), .BeatIdx(b_idx)
  );
  cosim_msg_splitter #(.MSG_BITS(32), .BEAT_BITS(32)) dut_c (
    .clk(clk), .rst(rst), .MsgValid(c_mv), .MsgReady(c_mr), .Msg(c_msg),
    .BeatValid(c_bv), .BeatReady(c_br), .Beat(c_beat), .BeatLast(c_last), .BeatIdx(c_idx)
  );

  typedef struct {
    int          dut;
    logic        mv;
    logic [95:0] msg;
    logic        br;
    logic        mr;
    logic        bv;
    logic [31:0] beat;
    logic [1:0]  idx;
    logic        last;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [95:0] M  = 96'h00000003_00000002_00000001;
  localparam logic [95:0] MA = 96'h000000A2_000000A1_000000A0;
  localparam logic [95:0] MB = 96'h000000B2_000000B1_000000B0;
  localparam logic [95:0] MC = 96'h000000C2_000000C1_000000C0;

  function automatic void add(int d, logic mv, logic [95:0] msg, logic br,
                              logic mr, logic bv, logic [31:0] beat, logic [1:0] idx, logic last);
    vec_t v;
    v.dut = d; v.mv = mv; v.msg = msg; v.br = br;
    v.mr = mr; v.bv = bv; v.beat = beat; v.idx = idx; v.last = last;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_mv = 0; a_br = 0; a_msg = '0;
    b_mv = 0; b_br = 0; b_msg = '0;
    c_mv = 0; c_br = 0; c_msg = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic mr, input logic bv,
                       input logic [31:0] beat, input logic [1:0] idx, input logic last);
    chk({tag, ".MsgReady"}, {95'd0, a_mr}, {95'd0, mr});
    chk({tag, ".BeatValid"}, {95'd0, a_bv}, {95'd0, bv});
    chk({tag, ".Beat"}, {64'd0, a_beat}, {64'd0, beat});
    chk({tag, ".BeatIdx"}, {94'd0, a_idx}, {94'd0, idx});
    chk({tag, ".BeatLast"}, {95'd0, a_last}, {95'd0, last});
  endtask

  initial begin
    idle_inputs();

    // DUT A: single message, full rate
    add(0, 1, M,  1, 1, 0, 32'h0, 0, 0);
    add(0, 0, '0, 1, 1, 1, 32'h1, 0, 0);
    add(0, 0, '0, 1, 1, 1, 32'h2, 1, 0);
    add(0, 0, '0, 1, 1, 1, 32'h3, 2, 1);
    add(0, 0, '0, 1, 1, 0, 32'h0, 0, 0);
    // DUT A: 4-cycle stall at beat 1
    add(0, 1, M,  1, 1, 0, 32'h0, 0, 0);
    add(0, 0, '0, 1, 1, 1, 32'h1, 0, 0);
    add(0, 0, '0, 0, 1, 1, 32'h2, 1, 0);
    add(0, 0, '0, 0, 1, 1, 32'h2, 1, 0);
    add(0, 0, '0, 0, 1, 1, 32'h2, 1, 0);
    add(0, 0, '0, 0, 1, 1, 32'h2, 1, 0);
    add(0, 0, '0, 1, 1, 1, 32'h2, 1, 0);
    add(0, 0, '0, 1, 1, 1, 32'h3, 2, 1);
    add(0, 0, '0, 1, 1, 0, 32'h0, 0, 0);
    // DUT A: three messages back-to-back, gap-free, order kept, MsgReady drops when full
    add(0, 1, MA, 1, 1, 0, 32'h0,  0, 0);
    add(0, 1, MB, 1, 1, 1, 32'hA0, 0, 0);
    add(0, 1, MC, 1, 0, 1, 32'hA1, 1, 0);
    add(0, 1, MC, 1, 0, 1, 32'hA2, 2, 1);
    add(0, 1, MC, 1, 1, 1, 32'hB0, 0, 0);
    add(0, 0, '0, 1, 0, 1, 32'hB1, 1, 0);
    add(0, 0, '0, 1, 0, 1, 32'hB2, 2, 1);
    add(0, 0, '0, 1, 1, 1, 32'hC0, 0, 0);
    add(0, 0, '0, 1, 1, 1, 32'hC1, 1, 0);
    add(0, 0, '0, 1, 1, 1, 32'hC2, 2, 1);
    add(0, 0, '0, 1, 1, 0, 32'h0,  0, 0);
    // DUT B: 40-bit message, padded final beat
    add(1, 1, 96'hAB_12345678, 1, 1, 0, 32'h0,        0, 0);
    add(1, 0, '0,              1, 1, 1, 32'h12345678, 0, 0);
    add(1, 0, '0,              1, 1, 1, 32'h000000AB, 1, 1);
    add(1, 0, '0,              1, 1, 0, 32'h0,        0, 0);
    // DUT C: one beat per message, one message per cycle
    add(2, 1, 96'h11, 1, 1, 0, 32'h0,  0, 0);
    add(2, 1, 96'h22, 1, 1, 1, 32'h11, 0, 1);
    add(2, 1, 96'h33, 1, 1, 1, 32'h22, 0, 1);
    add(2, 0, '0,     1, 1, 1, 32'h33, 0, 1);
    add(2, 0, '0,     1, 1, 0, 32'h0,  0, 0);

    // Reset values while held in reset
    repeat (2) step();
    chk_a("reset", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    chk("reset.b_MsgReady", {95'd0, b_mr}, 96'd1);
    chk("reset.c_BeatValid", {95'd0, c_bv}, 96'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      logic        g_mr, g_bv, g_last;
      logic [31:0] g_beat;
      logic [1:0]  g_idx;
      string       tag;
      v = vecs[i];
      idle_inputs();
      case (v.dut)
        0: begin a_mv = v.mv; a_msg = v.msg;        a_br = v.br; end
        1: begin b_mv = v.mv; b_msg = v.msg[39:0];  b_br = v.br; end
        default: begin c_mv = v.mv; c_msg = v.msg[31:0]; c_br = v.br; end
      endcase
      case (v.dut)
        0: begin g_mr = a_mr; g_bv = a_bv; g_beat = a_beat; g_idx = a_idx;         g_last = a_last; end
        1: begin g_mr = b_mr; g_bv = b_bv; g_beat = b_beat; g_idx = {1'b0, b_idx}; g_last = b_last; end
        default: begin g_mr = c_mr; g_bv = c_bv; g_beat = c_beat; g_idx = {1'b0, c_idx}; g_last = c_last; end
      endcase
      tag = $sformatf("vec%0d", i);
      $display("vec %0d dut=%0d mv=%0b br=%0b : mr=%0b bv=%0b beat=%08h idx=%0d last=%0b",
               i, v.dut, v.mv, v.br, g_mr, g_bv, g_beat, g_idx, g_last);
      chk({tag, ".MsgReady"}, {95'd0, g_mr}, {95'd0, v.mr});
      chk({tag, ".BeatValid"}, {95'd0, g_bv}, {95'd0, v.bv});
      chk({tag, ".Beat"}, {64'd0, g_beat}, {64'd0, v.beat});
      chk({tag, ".BeatIdx"}, {94'd0, g_idx}, {94'd0, v.idx});
      chk({tag, ".BeatLast"}, {95'd0, g_last}, {95'd0, v.last});
      step();
    end

    // Reset during beat 1 of a message with a second message buffered
    idle_inputs();
    a_mv = 1; a_msg = M; a_br = 1;
    step();
    a_mv = 1; a_msg = MA; a_br = 1;
    chk_a("rstseq.beat0", 1'b1, 1'b1, 32'h1, 2'd0, 1'b0);
    step();
    a_mv = 0; a_br = 0;
    chk_a("rstseq.beat1", 1'b0, 1'b1, 32'h2, 2'd1, 1'b0);
    $display("rstseq: asserting reset mid-message");
    rst = 1'b0;
    #1;
    chk_a("rstseq.inreset", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    step();
    rst = 1'b1;
    a_br = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_a($sformatf("rstseq.after%0d", k), 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);
    end
    a_mv = 1; a_msg = MB;
    step();
    a_mv = 0;
    chk_a("rstseq.fresh0", 1'b1, 1'b1, 32'hB0, 2'd0, 1'b0);
    step();
    chk_a("rstseq.fresh1", 1'b1, 1'b1, 32'hB1, 2'd1, 1'b0);
    step();
    chk_a("rstseq.fresh2", 1'b1, 1'b1, 32'hB2, 2'd2, 1'b1);
    step();
    chk_a("rstseq.idle", 1'b1, 1'b0, 32'h0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
